// File: rtl/gl_derivative_seq_if.sv
// Sample/coefficient/result bundle for the GL fractional-order operator.
// The host or integrator drives the master side and the operator drives the slave side.
interface gl_derivative_seq_if #(
  parameter int AW = 6
);
  logic signed [31:0] Signal;
  logic               InInd;
  logic               coef_we;
  logic [AW-1:0]      coef_addr;
  logic signed [31:0] coef_data;
  logic signed [31:0] Output;
  logic               OutInd;
  logic               Busy;
  logic               Overrun;

  modport master (
    output Signal, InInd, coef_we, coef_addr, coef_data,
    input  Output, OutInd, Busy, Overrun
  );

  modport slave (
    input  Signal, InInd, coef_we, coef_addr, coef_data,
    output Output, OutInd, Busy, Overrun
  );
endinterface

// File: rtl/gl_derivative_seq.sv
// Time-multiplexed Grunwald-Letnikov operator: y[n] = sum c[k]*x[n-k] over a WLength-deep
// history, one tap per cycle on a shared multiplier, toggle-strobed Q8.24 in and out.
module gl_derivative_seq #(
  parameter int WLength = 64,
  parameter int AW      = 6
) (
  input  logic              clk,
  input  logic              rst,
  gl_derivative_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  localparam logic [AW-1:0] L_ONE_A  = AW'(1);
  localparam logic [AW-1:0] L_LAST_K = AW'(WLength - 1);
  localparam logic [AW:0]   L_ONE_C  = (AW+1)'(1);
  localparam logic [AW:0]   L_FULL   = (AW+1)'(WLength);

  state_t             r_state, w_next;
  logic               r_in_ind;
  logic signed [31:0] r_coef [WLength];
  logic signed [31:0] r_hist [WLength];
  logic [AW-1:0]      r_wptr, r_k;
  logic [AW:0]        r_count;
  logic signed [47:0] r_acc;
  logic signed [31:0] r_out;
  logic               r_out_ind, r_busy, r_overrun;

  logic               w_strobe, w_capture, w_coef_wr, w_mac, w_done, w_drop;
  logic [AW-1:0]      w_rd_addr;
  logic signed [31:0] w_x, w_c;
  logic signed [63:0] w_prod, w_shift;
  logic signed [47:0] w_term;
  logic signed [31:0] w_sat;

  // Reset loads the live strobe level so releasing reset never looks like a new sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_in_ind <= bus.InInd;
    else      r_in_ind <= bus.InInd;
  end

  assign w_strobe = r_in_ind ^ bus.InInd;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_coef_wr = 1'b0;
    w_mac     = 1'b0;
    w_done    = 1'b0;
    w_drop    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_strobe) begin
          w_capture = 1'b1;
          w_next    = MAC;
        end else if (bus.coef_we) begin
          w_coef_wr = 1'b1;
        end
      end
      MAC: begin
        w_mac  = 1'b1;
        w_drop = w_strobe;
        if (r_k == L_LAST_K) w_next = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        w_drop = w_strobe;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Tap k looks back k samples from the newest, which sits just behind the write pointer.
  assign w_rd_addr = r_wptr - L_ONE_A - r_k;
  assign w_x       = r_hist[w_rd_addr];
  assign w_c       = r_coef[r_k];
  assign w_prod    = $signed({{32{w_c[31]}}, w_c}) * $signed({{32{w_x[31]}}, w_x});
  assign w_shift   = w_prod >>> 24;
  assign w_term    = ({1'b0, r_k} >= r_count) ? 48'sd0 : w_shift[47:0];

  always_comb begin
    w_sat = r_acc[31:0];
    if (r_acc > 48'sh0000_7FFF_FFFF)       w_sat = 32'sh7FFF_FFFF;
    else if (r_acc < -48'sh0000_8000_0000) w_sat = 32'sh8000_0000;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_wptr    <= '0;
      r_count   <= '0;
      r_k       <= '0;
      r_acc     <= '0;
      r_out     <= '0;
      r_out_ind <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_drop) r_overrun <= 1'b1;
      if (w_capture) begin
        r_wptr  <= r_wptr + L_ONE_A;
        r_count <= (r_count == L_FULL) ? r_count : r_count + L_ONE_C;
        r_acc   <= '0;
        r_k     <= '0;
        r_busy  <= 1'b1;
      end
      if (w_mac) begin
        r_acc <= r_acc + w_term;
        r_k   <= r_k + L_ONE_A;
      end
      if (w_done) begin
        r_out     <= w_sat;
        r_out_ind <= ~r_out_ind;
        r_busy    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WLength; i++) r_coef[i] <= '0;
    end else if (w_coef_wr) begin
      r_coef[bus.coef_addr] <= bus.coef_data;
    end
  end

  // NOTE: the history is plain RAM without reset; stale entries are masked by the valid count.
  always_ff @(posedge clk) begin
    if (w_capture) r_hist[r_wptr] <= bus.Signal;
  end

  assign bus.Output  = r_out;
  assign bus.OutInd  = r_out_ind;
  assign bus.Busy    = r_busy;
  assign bus.Overrun = r_overrun;

endmodule

// File: tb/tb_gl_derivative_seq.sv
// Scoreboard bench for gl_derivative_seq: the driver queues hand-computed results with their
// due cycle, and a monitor checks each OutInd toggle against the head of the queue.
module tb_gl_derivative_seq;

  localparam int WL  = 64;
  localparam int AW  = 6;
  localparam int LAT = WL + 2;
  localparam logic [31:0] ONE = 32'h0100_0000;

  typedef struct {
    logic [31:0] data;
    int          due;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  gl_derivative_seq_if #(.AW(AW)) bus ();

  gl_derivative_seq #(.WLength(WL), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: any OutInd change while out of reset must match the oldest queued expectation.
  initial begin
    logic last_ind;
    last_ind = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_ind = bus.OutInd;
      end else if (bus.OutInd !== last_ind) begin
        last_ind = bus.OutInd;
        if (sb.size() == 0) begin
          check("unexpected_outind", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_data"}, {32'd0, bus.Output}, {32'd0, e.data});
          check({e.name, "_cycle"}, 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  task automatic send(input logic [31:0] x, input bit has_exp, input logic [31:0] y,
                      input string name);
    @(posedge clk); #1;
    bus.Signal = x;
    bus.InInd  = ~bus.InInd;
    if (has_exp) sb.push_back('{y, cyc + LAT, name});
  endtask

  task automatic write_coef(input int addr, input logic [31:0] data);
    @(posedge clk); #1;
    bus.coef_we   = 1'b1;
    bus.coef_addr = AW'(addr);
    bus.coef_data = data;
    @(posedge clk); #1;
    bus.coef_we   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4 * LAT; i++) begin
      @(posedge clk); #1;
      if (!bus.Busy) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_idle_timeout"}, 64'(ok), 64'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    bus.Signal    = '0;
    bus.InInd     = 1'b0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_output",  {32'd0, bus.Output}, 64'd0);
    check("reset_outind",  64'(bus.OutInd),  64'd0);
    check("reset_busy",    64'(bus.Busy),    64'd0);
    check("reset_overrun", 64'(bus.Overrun), 64'd0);
    rst = 1'b1;

    // Impulse response through c[0]=1.0, c[1]=-0.1.
    write_coef(0, ONE);
    write_coef(1, -32'sd1677722);
    send(ONE, 1'b1, ONE, "impulse0");
    @(posedge clk); #1;
    check("busy_after_capture", 64'(bus.Busy), 64'd1);
    wait_idle("impulse0");
    send(32'd0, 1'b1, -32'sd1677722, "impulse1");
    wait_idle("impulse1");
    send(32'd0, 1'b1, 32'd0, "impulse2");
    wait_idle("impulse2");

    // Count gating: all taps 1.0, only valid history contributes.
    pulse_reset();
    for (int k = 0; k < WL; k++) write_coef(k, ONE);
    send(ONE, 1'b1, 32'd16777216, "gate1");
    wait_idle("gate1");
    send(ONE, 1'b1, 32'd33554432, "gate2");
    wait_idle("gate2");
    send(ONE, 1'b1, 32'd50331648, "gate3");
    wait_idle("gate3");

    // Saturation at both rails.
    pulse_reset();
    write_coef(0, 32'h7FFF_FFFF);
    send(32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, "sat_pos");
    wait_idle("sat_pos");
    send(32'h8000_0000, 1'b1, 32'h8000_0000, "sat_neg");
    wait_idle("sat_neg");

    // Overrun: strobe 3 cycles into MAC, and one landing on the DONE edge, are both dropped.
    pulse_reset();
    write_coef(0, ONE);
    write_coef(1, ONE);
    send(ONE, 1'b1, ONE, "ovr_first");
    repeat (2) @(posedge clk);
    send(32'h0500_0000, 1'b0, 32'd0, "ovr_drop_mac");
    repeat (LAT - 5) @(posedge clk);
    send(32'h0700_0000, 1'b0, 32'd0, "ovr_drop_done");
    wait_idle("ovr_first");
    check("overrun_set", 64'(bus.Overrun), 64'd1);
    send(32'h0200_0000, 1'b1, 32'd50331648, "ovr_history");
    wait_idle("ovr_history");
    check("overrun_sticky", 64'(bus.Overrun), 64'd1);

    // Coefficient write during MAC is ignored for this and the next result.
    pulse_reset();
    write_coef(0, ONE);
    send(32'h0300_0000, 1'b1, 32'd50331648, "busy_wr0");
    repeat (5) @(posedge clk);
    #1;
    bus.coef_we   = 1'b1;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    @(posedge clk); #1;
    bus.coef_we   = 1'b0;
    wait_idle("busy_wr0");
    send(ONE, 1'b1, ONE, "busy_wr1");
    wait_idle("busy_wr1");
    check("busy_wr_no_overrun", 64'(bus.Overrun), 64'd0);

    // Reset in the middle of MAC aborts the result and clears coefficients.
    write_coef(1, ONE);
    send(ONE, 1'b0, 32'd0, "abort");
    repeat (11) @(posedge clk);
    #1;
    check("abort_busy_before", 64'(bus.Busy), 64'd1);
    rst = 1'b0;
    #1;
    check("abort_output",  {32'd0, bus.Output}, 64'd0);
    check("abort_outind",  64'(bus.OutInd),  64'd0);
    check("abort_busy",    64'(bus.Busy),    64'd0);
    check("abort_overrun", 64'(bus.Overrun), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    write_coef(0, 32'h0080_0000);
    send(ONE, 1'b1, 32'd8388608, "post_abort0");
    wait_idle("post_abort0");
    send(ONE, 1'b1, 32'd8388608, "post_abort1");
    wait_idle("post_abort1");

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gl_derivative_seq.md
Name: gl_derivative_seq

Overview:
- Time-multiplexed Grünwald-Letnikov fractional-order operator that sits downstream of the GL integrator.
- Consumes the integrator's toggle-strobed Q8.24 sample stream (Signal + OutInd-style toggle) and computes y[n] = sum over k of c[k]*x[n-k] over a WLength-deep sample history.
- Uses one shared multiplier and host-loadable coefficients, so the same block realises the derivative (or any order) that inverts the integrator.
- Emits results on the same toggle protocol it receives.

Parameters:
- WLength, 64, number of taps and depth of the sample history (power of 2, 2..256).
- AW, 6, address width, equal to log2(WLength).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous active-low reset; the block is in reset while rst=0.
- Signal  input  32  signed Q8.24 input sample, valid when InInd toggles.
- InInd  input  1  toggle strobe; every change of level delivers one new sample.
- coef_we  input  1  coefficient write enable.
- coef_addr  input  AW  coefficient index k.
- coef_data  input  32  signed Q8.24 coefficient c[k].
- Output  output  32  signed Q8.24 result, saturated.
- OutInd  output  1  toggles once per new Output.
- Busy  output  1  high from sample capture until the result is issued.
- Overrun  output  1  sticky; set when a sample is dropped.

Behaviour:
- Reset (rst=0, async): Output=0, OutInd=0, Busy=0, Overrun=0.
- Reset also clears all c[k] to 0, write pointer to 0, valid count to 0, accumulator to 0, state to IDLE.
- Reset also loads the InInd edge detector with the current InInd, so no spurious capture happens on release.
- History RAM is not cleared. Taps with k >= count contribute 0.
- Strobe detect: new sample when the registered InInd differs from the live InInd. The registered copy updates every cycle.
- FSM states: IDLE, MAC, DONE.
- IDLE + strobe:
  - write Signal to hist[wptr];
  - wptr <= wptr+1 (mod WLength);
  - count <= min(count+1, WLength);
  - acc <= 0, k <= 0, Busy <= 1, go to MAC.
- MAC: one tap per cycle.
  - Tap k reads hist[(newest_ptr - k) mod WLength].
  - Product p = 64-bit signed c[k]*x.
  - Term = p >>> 24 (arithmetic shift, truncation toward negative infinity), sign-extended into a 48-bit signed accumulator.
  - Term is forced to 0 when k >= count.
  - After k = WLength-1, go to DONE.
- DONE:
  - Output <= acc saturated to [0x80000000, 0x7FFFFFFF];
  - OutInd <= ~OutInd, Busy <= 0, go to IDLE.
- Latency: Output and OutInd change on the (WLength+2)th rising edge after the capture edge. Capture is edge 1, MAC is edges 2..WLength+1, DONE is edge WLength+2.
- Throughput: one sample per WLength+2 cycles.
- Strobe while Busy=1 (MAC or DONE): sample dropped, history unchanged, Overrun <= 1 (held until reset).
- Strobe on the same edge that DONE returns to IDLE: counts as Busy and is dropped.
- Coefficient write: accepted only in IDLE with no strobe that cycle; c[coef_addr] <= coef_data. Otherwise ignored with no flag. A write and a strobe in the same IDLE cycle: the strobe wins and the write is ignored.
- Wrap-around: wptr wraps silently. Once count = WLength, the oldest sample is overwritten.
- Reset mid-MAC: computation aborted, no OutInd toggle, outputs return to reset values immediately.

Test Plan:
- Impulse: load c[0]=16777216, c[1]=-1677722, others 0; send x=16777216 then x=0 then x=0 -> Output 16777216, -1677722, 0; OutInd toggles 3 times, each WLength+2 cycles after its strobe.
- Count gating: c[k]=16777216 for all k; send 3 samples of 16777216 -> Outputs 16777216, 33554432, 50331648 (unwritten history ignored).
- Saturation: c[0]=0x7FFFFFFF, x=0x7FFFFFFF -> Output 0x7FFFFFFF. Then x=0x80000000 -> Output 0x80000000.
- Overrun: toggle InInd twice 3 cycles apart -> one OutInd toggle, Overrun=1 and stays 1; history holds only the first sample.
- Reset mid-MAC: drop rst to 0 at MAC cycle 10 -> Output=0, OutInd=0, Busy=0, c[]=0 asynchronously. After release, load c[0]=8388608 and send x=16777216 -> Output 8388608.
- Coefficient write during Busy ignored: write c[0]=0 during MAC -> that and the next result still use the old c[0]; Overrun unaffected.
